// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, sign fix-up. Define MULDIV_FASTPATH_EN to retire trivial operations in one cycle.
module muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [5:0]      LAST_STEP = 6'(ITER - 1);
  localparam logic [XLEN-1:0] ONES      = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [5:0]          cnt_q;
  logic [2:0]          funct3_q;
  logic [XLEN-1:0]     rs1_q, b_mag_q, result_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                sign_q, dz_q, ovf_q;

  logic                a_signed, b_signed, a_neg, b_neg, sign_in, dz_in, ovf_in;
  logic                accept, fast_in;
  logic [XLEN-1:0]     a_mag, b_mag;

  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] m);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    return {sum, acc[XLEN-1:1]};
  endfunction

  // Partial remainder lives in the upper half; quotient bits shift in at the bottom.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] d);
    logic [2*XLEN-1:0] sh;
    logic [XLEN:0]     trial;
    sh    = {acc[2*XLEN-2:0], 1'b0};
    trial = {acc[2*XLEN-1], sh[2*XLEN-1:XLEN]} - {1'b0, d};
    if (!trial[XLEN]) return {trial[XLEN-1:0], sh[XLEN-1:1], 1'b1};
    return sh;
  endfunction

  function automatic logic [XLEN-1:0] fix_result(input logic [2:0] f3,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic sgn, input logic dz, input logic ovf,
                                                 input logic [XLEN-1:0] dividend);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = sgn ? -acc : acc;
    quo  = sgn ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sgn ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      3'b000:         return prod[XLEN-1:0];
      3'b100, 3'b101: return dz ? ONES : (ovf ? MIN_NEG : quo);
      3'b110, 3'b111: return dz ? dividend : (ovf ? {XLEN{1'b0}} : rem);
      default:        return prod[2*XLEN-1:XLEN];
    endcase
  endfunction

`ifdef MULDIV_FASTPATH_EN
  function automatic logic [XLEN-1:0] special_result(input logic [2:0] f3, input logic dz,
                                                     input logic [XLEN-1:0] dividend);
    if (!f3[2]) return {XLEN{1'b0}};
    if (f3[1])  return dz ? dividend : {XLEN{1'b0}};
    return dz ? ONES : MIN_NEG;
  endfunction

  assign fast_in = funct3_i[2] ? (dz_in | ovf_in) : ((rs1_i == '0) | (rs2_i == '0));
`else
  assign fast_in = 1'b0;
`endif

  assign a_signed = !(funct3_i[0] & (funct3_i[1] | funct3_i[2]));
  assign b_signed = a_signed & (funct3_i != 3'b010);
  assign a_neg    = a_signed & rs1_i[XLEN-1];
  assign b_neg    = b_signed & rs2_i[XLEN-1];
  assign a_mag    = a_neg ? -rs1_i : rs1_i;
  assign b_mag    = b_neg ? -rs2_i : rs2_i;
  assign sign_in  = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
  assign dz_in    = funct3_i[2] & (rs2_i == '0);
  assign ovf_in   = funct3_i[2] & ~funct3_i[0] & (rs1_i == MIN_NEG) & (rs2_i == ONES);
  assign accept   = (state_q == S_IDLE) & start_i & ~kill_i;
  assign result_o = result_q;

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = fast_in ? S_DONE : S_CALC;
      S_CALC: begin
        busy_o = 1'b1;
        if (kill_i)                  state_d = S_IDLE;
        else if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        busy_o  = 1'b1;
        state_d = kill_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      rs1_q    <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (accept) begin
          funct3_q <= funct3_i;
          rs1_q    <= rs1_i;
          b_mag_q  <= b_mag;
          sign_q   <= sign_in;
          dz_q     <= dz_in;
          ovf_q    <= ovf_in;
          cnt_q    <= '0;
          acc_q    <= {{XLEN{1'b0}}, a_mag};
`ifdef MULDIV_FASTPATH_EN
          if (fast_in) result_q <= special_result(funct3_i, dz_in, rs1_i);
`endif
        end
        S_CALC: if (!kill_i) begin
          acc_q <= funct3_q[2] ? div_step(acc_q, b_mag_q) : mul_step(acc_q, b_mag_q);
          cnt_q <= cnt_q + 6'd1;
        end
        S_FIX: if (!kill_i) result_q <= fix_result(funct3_q, acc_q, sign_q, dz_q, ovf_q, rs1_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed spec cases, random operations against a native
// arithmetic model, kill/reset/ignored-start scenarios and done/busy timing.
module tb_muldiv_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  muldiv_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .kill_i(kill_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0]        ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sub = {32'b0, b};
    p   = '0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * sub;
      3'd3: p = ua * ub;
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
    return p[31:0];
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit c;
    if (f[2]) c = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      c = (a == 0) || (b == 0);
    return FAST_EN && c;
  endfunction

  // Called at a falling edge in IDLE; returns at the falling edge of the first cycle after acceptance.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3_i = f;
    rs1_i    = a;
    rs2_i    = b;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input bit fast, input bit poke);
    int k;
    int busy_err;
    bit seen;
    logic [31:0] exp, held;
    k = 1;
    busy_err = 0;
    seen = 1'b0;
    while (k <= 60) begin
      if (busy_o !== ((!fast && k <= 33) ? 1'b1 : 1'b0)) busy_err++;
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (k == 5) begin
        start_i = 1'b1;
        rs1_i   = ~rs1_i;
      end else if (k == 6) begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      k++;
    end
    start_i = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    if (seen) begin
      chk("latency", k, fast ? 32'd1 : 32'd34);
      chk("result", result_o, exp);
    end
    chk("busy_window", busy_err, 0);
    held = result_o;
    if (poke) begin
      funct3_i = 3'b000;
      rs1_i    = 32'd3;
      rs2_i    = 32'd3;
      start_i  = 1'b1;
    end
    @(negedge clk_i);
    start_i = 1'b0;
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("busy_after", 32'(busy_o), 32'd0);
    chk("result_hold", result_o, held);
  endtask

  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input bit poke);
    sb_q.push_back(exp);
    launch(f, a, b);
    wait_done(is_fast(f, a, b), poke);
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    kill_i   = 1'b0;
    funct3_i = '0;
    rs1_i    = '0;
    rs2_i    = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    op(3'b101, 32'd100,       32'd7,         32'd14,        1'b1);
    op(3'b111, 32'd100,       32'd7,         32'd2,         1'b0);
    op(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    op(3'b110, 32'd5,         32'd0,         32'd5,         1'b0);
    op(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b0);
    op(3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b0);
    op(3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0);
    op(3'b111, 32'd9,         32'd0,         32'd9,         1'b0);
    op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
    op(3'b001, 32'd0,         32'h1234_5678, 32'd0,         1'b0);

    for (int i = 0; i < 6; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      op(rf, ra, rb, ref_res(rf, ra, rb), 1'b0);
    end

    // Kill in CALC, then an immediate restart completes 34 cycles after its acceptance.
    prev = result_o;
    launch(3'b000, 32'd123, 32'd456);
    repeat (9) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    chk("kill_busy", 32'(busy_o), 32'd0);
    chk("kill_done", 32'(done_o), 32'd0);
    chk("kill_result", result_o, prev);
    op(3'b000, 32'd123, 32'd456, 32'd56088, 1'b0);

    // Kill together with start in IDLE drops the request.
    funct3_i = 3'b100;
    rs1_i    = 32'd5;
    rs2_i    = 32'd0;
    start_i  = 1'b1;
    kill_i   = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    kill_i   = 1'b0;
    chk("killstart_busy", 32'(busy_o), 32'd0);
    chk("killstart_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    chk("killstart_done2", 32'(done_o), 32'd0);

    // Asynchronous reset mid-operation.
    launch(3'b011, 32'd9, 32'd9);
    repeat (19) @(negedge clk_i);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2;
    reset_i = 1'b1;
    start_i = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_result", result_o, 32'd0);
    @(negedge clk_i);
    chk("rst_hold_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_done", 32'(done_o), 32'd0);
    op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the M-extension multiply/divide unit.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request from the execute stage.
- Does operand sign conditioning, then runs a 32-step radix-2 shift-add multiply or restoring divide, then sign correction.
- Returns a 32-bit result with a one-cycle done pulse; the pipeline stalls on busy_o.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- ITER, 32, iteration count of the CALC state; must equal XLEN.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request strobe; sampled only in IDLE
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  32  operand A / dividend
- rs2_i  in  32  operand B / divisor
- kill_i  in  1  pipeline flush; aborts the current operation
- busy_o  out  1  high while an accepted operation is in progress (CALC, FIX)
- done_o  out  1  one-cycle pulse; result_o valid in that cycle
- result_o  out  32  result; holds its value until the next done_o

Behaviour:
- Reset:
  - State IDLE; busy_o=0, done_o=0, result_o=0; all internal registers cleared.
  - Reset asserted mid-operation aborts it immediately; no done_o.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 at edge T latches funct3, rs1, rs2 and magnitudes (two's complement negate when the operand is treated signed and bit31=1).
  - Signedness per operand: MUL/MULH/DIV/REM both signed; MULHSU rs1 only; MULHU/DIVU/REMU none.
  - Result sign flag is latched at acceptance:
    - multiply: sign(A) XOR sign(B);
    - divide quotient: same;
    - remainder: sign of dividend.
- CALC: exactly ITER cycles (T+1..T+32), driven by a 6-bit counter.
  - Multiply: 64-bit accumulator; add multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: 64-bit remainder/quotient pair; shift left, trial-subtract, restore on borrow.
- FIX (T+33): negate the 64-bit product, quotient or remainder if the sign flag is set, then select:
  - MUL: low 32 bits; MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient; REM/REMU: remainder.
- DONE (T+34): done_o=1, result_o registered, busy_o=0. Next state IDLE.
  - start_i in DONE is ignored; it is accepted from the following IDLE cycle.
- busy_o: high T+1..T+33 inclusive.
- start_i while busy is ignored; no queuing.
- Special results, always architecturally correct regardless of the optional feature:
  - divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; matching REM -> 0.
  - These override the FIX selection.
- kill_i:
  - kill_i=1 in CALC or FIX: IDLE at the next edge, busy_o=0, no done_o; result_o unchanged.
  - kill_i=1 in DONE: done_o is still asserted.
  - kill_i with start_i in IDLE: kill wins; the request is dropped.
- Back-to-back operations: minimum spacing start-to-start is 35 cycles on the full path.

Optional Feature:
- MULDIV_FASTPATH_EN defined:
  - IDLE goes directly to DONE for: divisor zero, signed overflow, either multiply operand zero.
  - Result computed combinationally from latched values; done_o at T+1; busy_o never asserts.
- Undefined: every operation takes the full path; done_o at T+34 with identical result values.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB, done_o pulse at T+34, busy_o high T+1..T+33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Done at T+1 with MULDIV_FASTPATH_EN, T+34 without.
- kill_i at T+10 -> no done_o, busy_o=0 at T+11, result_o unchanged; new start_i at T+11 is accepted and completes at T+45.
- reset_i pulsed asynchronously at T+20 -> busy_o, done_o, result_o = 0 immediately; start_i ignored while busy and during reset.
